// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step tick driving OFF/COUNT/CHASE/BOUNCE patterns with PWM dimming.
// Define LED_PATTERN_SYNC_EN to pass i_Mode through a 2-flop synchronizer (asynchronous switches).
module led_pattern_gen #(
  parameter int unsigned NUM_LEDS   = 4,
  parameter int unsigned CLK_DIV    = 6250000,
  parameter int unsigned PWM_W      = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic [1:0]          i_Mode,
  input  logic [PWM_W-1:0]    i_Duty,
  output logic [NUM_LEDS-1:0] o_LED,
  output logic                o_Tick
);

  localparam int unsigned PreW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PreW-1:0]     PreLast = PreW'(CLK_DIV - 1);
  localparam logic [NUM_LEDS-1:0] OneHot  = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] LedIdle = {NUM_LEDS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    ModeOff    = 2'b00,
    ModeCount  = 2'b01,
    ModeChase  = 2'b10,
    ModeBounce = 2'b11
  } mode_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  logic [1:0] mode_in;

`ifdef LED_PATTERN_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= ModeOff;
      sync2_q <= ModeOff;
    end else begin
      sync1_q <= i_Mode;
      sync2_q <= sync1_q;
    end
  end

  assign mode_in = sync2_q;
`else
  assign mode_in = i_Mode;
`endif

  mode_e               mode_q, mode_prev_q;
  dir_e                dir_q, dir_d;
  logic [PreW-1:0]     pre_q, pre_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d;
  logic [PWM_W-1:0]    pwm_q;
  logic                mode_change, step, tick_d, pwm_on;
  logic [NUM_LEDS-1:0] lit, led_d;

  assign mode_change = (mode_q != mode_prev_q);
  assign step        = (pre_q == PreLast);
  // A mode change restarts the prescaler and suppresses a coincident step.
  assign tick_d      = step && !mode_change;
  assign pre_d       = (mode_change || step) ? '0 : pre_q + PreW'(1);

  always_comb begin
    pat_d = pat_q;
    dir_d = dir_q;
    if (mode_change) begin
      dir_d = DirUp;
      pat_d = (mode_q == ModeChase || mode_q == ModeBounce) ? OneHot : '0;
    end else if (step) begin
      unique case (mode_q)
        ModeOff:   pat_d = '0;
        ModeCount: pat_d = pat_q + NUM_LEDS'(1);
        ModeChase: pat_d = (pat_q << 1) | (pat_q >> (NUM_LEDS - 1));
        ModeBounce: begin
          if (NUM_LEDS == 1) begin
            pat_d = pat_q;
          end else if (dir_q == DirUp) begin
            pat_d = pat_q << 1;
            if (pat_d[NUM_LEDS-1]) dir_d = DirDown;
          end else begin
            pat_d = pat_q >> 1;
            if (pat_d[0]) dir_d = DirUp;
          end
        end
        default: pat_d = pat_q;
      endcase
    end
  end

  assign pwm_on = (pwm_q < i_Duty) || (&i_Duty);
  assign lit    = (mode_q == ModeOff) ? '0 : (pat_q & {NUM_LEDS{pwm_on}});
  assign led_d  = ACTIVE_LOW ? ~lit : lit;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      mode_q      <= ModeOff;
      mode_prev_q <= ModeOff;
      dir_q       <= DirUp;
      pre_q       <= '0;
      pat_q       <= '0;
      pwm_q       <= '0;
      o_Tick      <= 1'b0;
      o_LED       <= LedIdle;
    end else begin
      mode_q      <= mode_e'(mode_in);
      mode_prev_q <= mode_q;
      dir_q       <= dir_d;
      pre_q       <= pre_d;
      pat_q       <= pat_d;
      pwm_q       <= pwm_q + PWM_W'(1);
      o_Tick      <= tick_d;
      o_LED       <= led_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: pattern table plus reset, PWM and mode/tick collision cases.
// With LED_PATTERN_SYNC_EN defined the DUT is built non-inverted with synchronizer latency.
module tb_led_pattern_gen;

  localparam int unsigned NUM = 4;
  localparam int unsigned DIV = 4;
  localparam int unsigned PW  = 2;
`ifdef LED_PATTERN_SYNC_EN
  localparam bit ACT_LOW = 1'b0;
  localparam int LAT     = 4;
`else
  localparam bit ACT_LOW = 1'b1;
  localparam int LAT     = 2;
`endif

  localparam logic [1:0] OFF = 2'b00, CNT = 2'b01, CHS = 2'b10, BNC = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    mode = OFF;
  logic [PW-1:0] duty = '1;
  logic [NUM-1:0] led;
  logic          tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS  (NUM),
    .CLK_DIV   (DIV),
    .PWM_W     (PW),
    .ACTIVE_LOW(ACT_LOW)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .i_Mode (mode),
    .i_Duty (duty),
    .o_LED  (led),
    .o_Tick (tick)
  );

  typedef struct {
    logic [1:0]     mode;
    logic [PW-1:0]  duty;
    bit             restart;
    logic [NUM-1:0] lit;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [NUM-1:0] pin(input logic [NUM-1:0] l);
    return ACT_LOW ? ~l : l;
  endfunction

  function automatic void add(input logic [1:0] m, input logic [PW-1:0] d, input bit r,
                              input logic [NUM-1:0] l);
    vec_t v;
    v.mode = m; v.duty = d; v.restart = r; v.lit = l;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Counts clock edges until o_Tick is seen; 11 means the 10-cycle bound expired.
  task automatic wait_tick(output int n);
    n = 11;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pwm_window(input logic [PW-1:0] d, input int exp_lit);
    int lit_cnt;
    logic [NUM-1:0] l;
    duty = d;
    step();
    lit_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      l = ACT_LOW ? ~led : led;
      if (l != '0) begin
        lit_cnt++;
        check($sformatf("pwm_onehot_d%0d", d), $countones(l), 1);
      end
    end
    check($sformatf("pwm_lit_count_d%0d", d), lit_cnt, exp_lit);
  endtask

  initial begin
    int n;

    add(CNT, '1, 1'b1, 4'd0);
    for (int v = 1; v <= 16; v++) add(CNT, '1, 1'b0, 4'(v));
    add(BNC, '1, 1'b1, 4'b0001);
    add(BNC, '1, 1'b0, 4'b0010);
    add(BNC, '1, 1'b0, 4'b0100);
    add(BNC, '1, 1'b0, 4'b1000);
    add(BNC, '1, 1'b0, 4'b0100);
    add(BNC, '1, 1'b0, 4'b0010);
    add(BNC, '1, 1'b0, 4'b0001);
    add(BNC, '1, 1'b0, 4'b0010);
    add(CHS, '1, 1'b1, 4'b0001);
    add(CHS, '1, 1'b0, 4'b0010);
    add(CHS, '1, 1'b0, 4'b0100);
    add(CHS, '1, 1'b0, 4'b1000);
    add(CHS, '1, 1'b0, 4'b0001);
    add(OFF, '1, 1'b1, 4'b0000);
    add(OFF, '1, 1'b0, 4'b0000);
    add(OFF, '1, 1'b0, 4'b0000);

    // Reset held while inputs toggle.
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mode = 2'(i + 1);
      duty = PW'(i);
      step();
      check($sformatf("rst_led_%0d", i), led, pin('0));
      check($sformatf("rst_tick_%0d", i), tick, 0);
    end
    mode = OFF;
    duty = '1;
    rst_n = 1'b1;
    steps(2);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      duty = vecs[i].duty;
      if (vecs[i].restart) begin
        steps(LAT + 1);
        check($sformatf("vec%0d_reload", i), led, pin(vecs[i].lit));
      end else begin
        wait_tick(n);
        check($sformatf("vec%0d_tick_gap", i), n, 3);
        step();
        check($sformatf("vec%0d_led", i), led, pin(vecs[i].lit));
      end
    end

    // Asynchronous reset mid-pattern, then restart from reset.
    mode = CNT;
    steps(LAT + 1);
    wait_tick(n);
    step();
    check("pre_async_rst_led", led, pin(4'd1));
    #2 rst_n = 1'b0;
    #1 check("async_rst_led", led, pin('0));
    rst_n = 1'b1;
    wait_tick(n);
    check("post_rst_first_tick", n, LAT + 4);
    step();
    check("post_rst_led", led, pin(4'd1));

    // PWM dimming in CHASE.
    mode = CHS;
    steps(LAT + 1);
    pwm_window(2'd1, 2);
    pwm_window(2'd2, 4);
    pwm_window(2'd0, 0);
    pwm_window(2'd3, 8);

    // CHASE->COUNT change landing on the step cycle.
    duty = '1;
    wait_tick(n);
    check("collide_sync_tick", int'(n <= 4), 1);
    steps(4 - LAT);
    mode = CNT;
    steps(LAT - 1);
    check("collide_tick_pre", tick, 0);
    step();
    check("collide_no_tick", tick, 0);
    step();
    check("collide_reload_led", led, pin('0));
    wait_tick(n);
    check("collide_restart_gap", n, 3);
    step();
    check("collide_first_step", led, pin(4'd1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
